// File: rtl/cache_controller_pkg.sv
// Shared types and default geometry for the cache control FSM.
// Direct-mapped cache, 4-word blocks, word-addressed.
package cache_ctrl_pkg;

    localparam int ADDR_W      = 15;
    localparam int TAG_W       = 3;
    localparam int OFFSET_W    = 2;
    localparam int CNT_W       = 16;
    localparam int BLOCK_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Processor request, datapath control/feedback and statistics bundle.
// slave = controller side, master = processor + datapath side.
interface cache_ctrl_if
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = cache_ctrl_pkg::ADDR_W,
    parameter int OFFSET_W = cache_ctrl_pkg::OFFSET_W,
    parameter int CNT_W    = cache_ctrl_pkg::CNT_W
);
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_ready;
    logic                done;
    logic                fill_err;
    logic [ADDR_W-1:0]   address;
    logic                C_write_cache;
    logic                C_main_mem_miss;
    logic [OFFSET_W-1:0] C_offset;
    logic                cache_valid;
    logic                is_wanted_data;
    logic                main_mem_ready;
    logic [CNT_W-1:0]    access_count;
    logic [CNT_W-1:0]    hit_count;

    modport slave (
        input  req_valid, req_addr, cache_valid, is_wanted_data, main_mem_ready,
        output req_ready, done, fill_err, address, C_write_cache, C_main_mem_miss,
               C_offset, access_count, hit_count
    );

    modport master (
        output req_valid, req_addr, cache_valid, is_wanted_data, main_mem_ready,
        input  req_ready, done, fill_err, address, C_write_cache, C_main_mem_miss,
               C_offset, access_count, hit_count
    );
endinterface

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter; value registered, one cycle after inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;
endmodule

// File: rtl/cache_controller.sv
// Read-miss control FSM: lookup, block fill from main memory, one re-check.
// Hit done 2 cycles after accept; one request in flight, req_ready only in IDLE.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = cache_ctrl_pkg::ADDR_W,
    parameter int OFFSET_W = cache_ctrl_pkg::OFFSET_W,
    parameter int CNT_W    = cache_ctrl_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.slave  bus
);
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(BLOCK_WORDS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [OFFSET_W-1:0] r_off_cnt;
    logic                r_retry;
    logic                r_fill_err;

    logic                w_hit;
    logic                w_accept;
    logic                w_hit_inc;
    logic [ADDR_W-1:0]   w_blk_addr;
    logic [ADDR_W-1:0]   w_address;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_write;
    logic                w_miss;
    logic                w_ready;
    logic                w_done;
    logic [CNT_W-1:0]    w_access_count;
    logic [CNT_W-1:0]    w_hit_count;

    assign w_hit      = bus.cache_valid & bus.is_wanted_data;
    assign w_accept   = (r_state == IDLE) & bus.req_valid;
    assign w_hit_inc  = (r_state == LOOKUP) & w_hit & ~r_retry;
    assign w_blk_addr = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_address = r_addr;
        w_offset  = '0;
        w_write   = 1'b0;
        w_miss    = 1'b0;
        w_ready   = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) w_next = LOOKUP;
            end
            LOOKUP: begin
                // A miss after the fill means the datapath disagrees; report it, never refill.
                if (w_hit || r_retry) w_next = DONE;
                else                  w_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                w_address = w_blk_addr;
                w_miss    = 1'b1;
                if (bus.main_mem_ready) w_next = FILL;
            end
            FILL: begin
                w_address = w_blk_addr;
                w_miss    = 1'b1;
                w_write   = 1'b1;
                w_offset  = r_off_cnt;
                if (r_off_cnt == LAST_OFF) w_next = LOOKUP;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= '0;
            r_off_cnt  <= '0;
            r_retry    <= 1'b0;
            r_fill_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr;
                        r_retry <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (!w_hit && r_retry) r_fill_err <= 1'b1;
                end
                MEM_WAIT: r_off_cnt <= '0;
                FILL: begin
                    r_off_cnt <= r_off_cnt + 1'b1;
                    if (r_off_cnt == LAST_OFF) r_retry <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_access_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept),
        .value (w_access_count)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .value (w_hit_count)
    );

    assign bus.req_ready       = w_ready;
    assign bus.done            = w_done;
    assign bus.fill_err        = r_fill_err;
    assign bus.address         = w_address;
    assign bus.C_write_cache   = w_write;
    assign bus.C_main_mem_miss = w_miss;
    assign bus.C_offset        = w_offset;
    assign bus.access_count    = w_access_count;
    assign bus.hit_count       = w_hit_count;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: emulated direct-mapped datapath + main memory,
// table vectors, hand-written corner sequences and a randomized reference model.
module tb_cache_controller;
    localparam int AW    = 15;
    localparam int OW    = 2;
    localparam int TW    = 3;
    localparam int IW    = AW - TW - OW;
    localparam int LINES = 1 << IW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();
    cache_ctrl_if #(.CNT_W(4)) bus_s ();

    cache_controller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter instance kept permanently hitting, for the saturation boundary.
    cache_controller #(.CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.req_valid      = 1'b1;
    assign bus_s.req_addr       = 15'h0040;
    assign bus_s.cache_valid    = 1'b1;
    assign bus_s.is_wanted_data = 1'b1;
    assign bus_s.main_mem_ready = 1'b1;

    // Datapath emulation: tag store written by the DUT's fill cycles.
    logic          line_vld [LINES];
    logic [TW-1:0] line_tag [LINES];
    logic          force_hit = 1'b0;
    logic          poison    = 1'b0;
    int            mem_delay = 0;
    int            wait_cnt  = 0;

    assign bus.cache_valid    = force_hit | line_vld[bus.address[AW-TW-1:OW]];
    assign bus.is_wanted_data = !poison &&
        (force_hit || (line_tag[bus.address[AW-TW-1:OW]] == bus.address[AW-1 -: TW]));

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW-1:0] tr_addr [32];
    logic [OW-1:0] tr_off  [32];
    logic          tr_wr   [32];
    logic          tr_miss [32];

    typedef struct {
        logic [AW-1:0] addr;
        bit            fh;
        bit            psn;
        int            dly;
        bit            noise;
        int            e_lat;
        bit            e_fetch;
        int            e_acc;
        int            e_hit;
        bit            e_err;
    } vec_t;

    vec_t vt [8];

    bit            ref_v [LINES];
    logic [TW-1:0] ref_t [LINES];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic clear_cache();
        for (int i = 0; i < LINES; i++) begin
            line_vld[i] = 1'b0;
            line_tag[i] = '0;
            ref_v[i]    = 1'b0;
            ref_t[i]    = '0;
        end
    endtask

    // One clock: commit any fill write seen this cycle, advance, then play main memory.
    task automatic step();
        if (rst && bus.C_write_cache) begin
            line_vld[bus.address[AW-TW-1:OW]] = 1'b1;
            line_tag[bus.address[AW-TW-1:OW]] = bus.address[AW-1 -: TW];
        end
        @(posedge clk);
        #1;
        if (bus.C_main_mem_miss && !bus.C_write_cache) begin
            bus.main_mem_ready = (wait_cnt >= mem_delay);
            wait_cnt++;
        end else begin
            bus.main_mem_ready = 1'b0;
            wait_cnt = 0;
        end
    endtask

    // Issue one request; lat = cycle of done counted from the accepting edge, -1 on timeout.
    task automatic do_req(input logic [AW-1:0] a, input bit noise,
                          output int lat, output bit fetched, output int nwr);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        step();
        lat     = 1;
        fetched = 1'b0;
        nwr     = 0;
        while (!bus.done && lat < 100) begin
            if (lat < 32) begin
                tr_addr[lat] = bus.address;
                tr_off[lat]  = bus.C_offset;
                tr_wr[lat]   = bus.C_write_cache;
                tr_miss[lat] = bus.C_main_mem_miss;
            end
            if (bus.C_main_mem_miss) fetched = 1'b1;
            if (bus.C_write_cache) nwr++;
            bus.req_valid = noise;
            bus.req_addr  = AW'($urandom);
            step();
            lat++;
        end
        bus.req_valid = 1'b0;
        if (!bus.done) lat = -1;
    endtask

    initial begin
        int            lat;
        int            nwr;
        int            n;
        int            e_acc;
        int            e_hits;
        bit            f;
        bit            hit;
        logic [AW-1:0] a;
        logic [IW-1:0] id;

        vt[0] = '{15'h1234, 1'b1, 1'b0, 0, 1'b0,  2, 1'b0, 2, 1, 1'b0};
        vt[1] = '{15'h2A05, 1'b0, 1'b0, 0, 1'b0,  2, 1'b0, 3, 2, 1'b0};
        vt[2] = '{15'h0100, 1'b0, 1'b0, 5, 1'b1, 13, 1'b1, 4, 2, 1'b0};
        vt[3] = '{15'h4100, 1'b0, 1'b0, 0, 1'b1,  8, 1'b1, 5, 2, 1'b0};
        vt[4] = '{15'h0102, 1'b0, 1'b0, 0, 1'b0,  8, 1'b1, 6, 2, 1'b0};
        vt[5] = '{15'h0103, 1'b0, 1'b0, 0, 1'b0,  2, 1'b0, 7, 3, 1'b0};
        vt[6] = '{15'h7FFF, 1'b0, 1'b1, 0, 1'b0,  8, 1'b1, 8, 3, 1'b1};
        vt[7] = '{15'h1235, 1'b1, 1'b0, 0, 1'b0,  2, 1'b0, 9, 4, 1'b1};

        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.main_mem_ready = 1'b0;
        clear_cache();

        // Reset held for two edges.
        rst = 1'b0;
        step();
        step();
        chk("rst_outputs",
            {bus.req_ready, bus.done, bus.fill_err, bus.C_write_cache,
             bus.C_main_mem_miss, bus.C_offset, bus.address},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0000});
        chk("rst_counts", {bus.access_count, bus.hit_count}, 32'h0);
        rst = 1'b1;
        step();

        // Cold miss with full control trace.
        do_req(15'h2A07, 1'b0, lat, f, nwr);
        chk("miss_lat", lat, 8);
        chk("miss_c1_lookup", {tr_miss[1], tr_wr[1], tr_addr[1]}, {1'b0, 1'b0, 15'h2A07});
        chk("miss_c2_memwait", {tr_miss[2], tr_wr[2], tr_off[2], tr_addr[2]},
            {1'b1, 1'b0, 2'd0, 15'h2A04});
        for (int c = 3; c <= 6; c++)
            chk($sformatf("fill_c%0d", c), {tr_miss[c], tr_wr[c], tr_off[c], tr_addr[c]},
                {1'b1, 1'b1, 2'(c - 3), 15'h2A04});
        chk("miss_c7_relookup", {tr_miss[7], tr_wr[7], tr_addr[7]}, {1'b0, 1'b0, 15'h2A07});
        chk("miss_counts", {bus.access_count, bus.hit_count}, {16'd1, 16'd0});

        for (int i = 0; i < 8; i++) begin
            force_hit = vt[i].fh;
            poison    = vt[i].psn;
            mem_delay = vt[i].dly;
            do_req(vt[i].addr, vt[i].noise, lat, f, nwr);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].e_lat);
            chk($sformatf("vec%0d_fetch", i), f, vt[i].e_fetch);
            chk($sformatf("vec%0d_writes", i), nwr, vt[i].e_fetch ? 4 : 0);
            chk($sformatf("vec%0d_access", i), bus.access_count, vt[i].e_acc);
            chk($sformatf("vec%0d_hits", i), bus.hit_count, vt[i].e_hit);
            chk($sformatf("vec%0d_fill_err", i), bus.fill_err, vt[i].e_err);
            if (vt[i].dly > 0)
                for (int c = 2; c <= 2 + vt[i].dly; c++)
                    chk($sformatf("vec%0d_wait_c%0d", i, c), {tr_miss[c], tr_wr[c]}, 2'b10);
        end
        force_hit = 1'b0;
        poison    = 1'b0;
        mem_delay = 0;

        // Reset landing on the third fill beat.
        step();
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h5555;
        step();
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.C_write_cache && bus.C_offset == 2'd2) && n < 50) begin
            step();
            n++;
        end
        chk("reach_fill_off2", n < 50, 1);
        rst = 1'b0;
        step();
        chk("rst_midfill_outputs",
            {bus.req_ready, bus.done, bus.fill_err, bus.C_write_cache,
             bus.C_main_mem_miss, bus.C_offset, bus.address},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15'h0000});
        chk("rst_midfill_counts", {bus.access_count, bus.hit_count}, 32'h0);
        rst = 1'b1;
        clear_cache();

        // About 20 back-to-back hits on the 4-bit counter instance.
        for (int k = 0; k < 60; k++) step();
        chk("sat_hit_count", bus_s.hit_count, 4'hF);
        chk("sat_access_count", bus_s.access_count, 4'hF);

        // Random traffic against a tag-store reference.
        e_acc  = 0;
        e_hits = 0;
        for (int k = 0; k < 60; k++) begin
            a         = {3'($urandom_range(7)), 8'h00, 2'($urandom_range(3)), 2'($urandom_range(3))};
            mem_delay = $urandom_range(3);
            id        = a[AW-TW-1:OW];
            hit       = ref_v[id] && (ref_t[id] == a[AW-1 -: TW]);
            do_req(a, 1'($urandom_range(1)), lat, f, nwr);
            e_acc++;
            if (hit) e_hits++;
            ref_v[id] = 1'b1;
            ref_t[id] = a[AW-1 -: TW];
            chk($sformatf("rnd%0d_lat", k), lat, hit ? 2 : 8 + mem_delay);
            chk($sformatf("rnd%0d_fetch", k), f, !hit);
            chk($sformatf("rnd%0d_access", k), bus.access_count, e_acc);
            chk($sformatf("rnd%0d_hits", k), bus.hit_count, e_hits);
            chk($sformatf("rnd%0d_fill_err", k), bus.fill_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Control FSM directly upstream of the cache/main-memory datapath. Accepts single-word read requests from the processor side, drives the datapath's address, cache-write, memory-miss and block-offset controls, and evaluates the datapath's valid/tag-match/ready feedback to decide hit or miss. On a miss it performs a 4-word block fill from main memory into the direct-mapped cache, then re-checks. It also keeps saturating access/hit statistics.

## Interface
- ADDR_W, 15, word address width
- TAG_W, 3, tag width; tag = address[ADDR_W-1 -: TAG_W]
- OFFSET_W, 2, block-offset width (4 words per block)
- CNT_W, 16, statistics counter width
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  processor read request; sampled only when req_ready=1
- req_addr  in  ADDR_W  request word address, sampled with req_valid
- req_ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse: requested word is present in the cache
- fill_err  out  1  sticky; set when post-fill re-lookup still misses
- address  out  ADDR_W  address to datapath
- C_write_cache  out  1  cache write enable
- C_main_mem_miss  out  1  main-memory fetch request
- C_offset  out  OFFSET_W  word offset within block
- cache_valid  in  1  valid bit of the indexed line
- is_wanted_data  in  1  tag match of indexed line against address
- main_mem_ready  in  1  main memory has block data available
- access_count  out  CNT_W  accepted requests, saturating
- hit_count  out  CNT_W  first-lookup hits, saturating

## Operation
- States: IDLE, LOOKUP, MEM_WAIT, FILL, DONE.
- IDLE: req_ready=1. When req_valid=1, latch req_addr into addr_q, clear retry flag, increment access_count, go to LOOKUP.
- LOOKUP: address=addr_q, C_offset=0, C_write_cache=0, C_main_mem_miss=0. Hit = cache_valid & is_wanted_data.
  - Hit: go to DONE. Increment hit_count only if retry=0.
  - Miss, retry=0: go to MEM_WAIT.
  - Miss, retry=1: set fill_err and go to DONE. No second fill.
- MEM_WAIT: address={addr_q[ADDR_W-1:OFFSET_W], 0}, C_main_mem_miss=1, C_offset=0. Remain in MEM_WAIT until main_mem_ready=1, then go to FILL with off_cnt=0.
- FILL: block-aligned address, C_main_mem_miss=1, C_write_cache=1, C_offset=off_cnt. off_cnt increments each cycle. After off_cnt=3, set retry=1 and go to LOOKUP. main_mem_ready is not rechecked during FILL.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Counters saturate at all-ones and never wrap.
- fill_err is cleared only by reset.

## Timing
- Reset (rst=0 at an edge): state=IDLE, addr_q=0, off_cnt=0, retry=0, counters=0, fill_err=0. Reset values of outputs: address=0, C_*=0, done=0, req_ready=1. Reset mid-fill aborts the fill immediately; partially written lines are not invalidated.
- All control outputs are Moore decodes of the registered state, off_cnt and addr_q. None depend combinationally on the inputs.
- Hit latency: request accepted at edge 0 → LOOKUP during cycle 1 → done during cycle 2 → req_ready back during cycle 3.
- Miss latency, with ready on first MEM_WAIT cycle: LOOKUP c1, MEM_WAIT c2, FILL c3–c6, LOOKUP c7, done c8.
- A req_valid arriving while req_ready=0 is ignored and not queued.
- Only one request is in flight at a time.

## Structure
- Package cache_ctrl_pkg holds:
  - state enum (IDLE, LOOKUP, MEM_WAIT, FILL, DONE)
  - ADDR_W/TAG_W/OFFSET_W/CNT_W defaults
  - BLOCK_WORDS=4
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output value) is instantiated twice, for access_count and hit_count.
- Top level: FSM, addr_q/off_cnt/retry/fill_err registers, output decode.

## Test plan
- Reset then idle: rst low for 2 cycles → all C_* =0, req_ready=1, counters 0, fill_err 0.
- Hit on address 0x1234: tie cache_valid=1 and is_wanted_data=1. Expect done at cycle 2, hit_count=1, access_count=1, and no C_main_mem_miss.
- Miss on address 0x2A07: model returns miss first, then hit after fill. Expect:
  - C_main_mem_miss high from c2.
  - Fill at address 0x2A04 with C_offset 0,1,2,3 and C_write_cache=1 over c3–c6.
  - done at c8, hit_count=0, access_count=1.
- main_mem_ready held low for 5 cycles: FSM stays in MEM_WAIT with C_main_mem_miss=1 and C_write_cache=0, then fills normally.
- Persistent miss (tag never matches): one fill only, then fill_err=1 and done pulse; fill_err stays 1 for the next successful hit.
- Boundaries:
  - req_valid during FILL is ignored (access_count unchanged).
  - rst=0 at FILL off_cnt=2 returns to IDLE with all outputs 0.
  - 65536 hits saturate hit_count at 0xFFFF.
